// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: writeback trace recorder for the venus core.
// Captures every EX->RF writeback as {cycle stamp, rd_num, rd_data, status}
// into a circular buffer under arm / trigger / post-trigger-count control,
// then drains the buffer oldest-first once capture has stopped.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   arm_i           clear buffer and start capture (wins over everything)
//   trig_i          trigger event, honoured in ARMED only
//   post_cnt_i      writebacks to capture after the trigger (saturates at DEPTH)
//   wb_i, rd_num_i, rd_data_i, status_i   writeback tap
//   rd_i            pop the presented entry (DONE only)
//   rd_valid_o, rd_cyc_o, rd_num_o, rd_data_o, rd_stat_o   presented entry
//   count_o         entries held, 0..DEPTH
//   state_o         IDLE=00 ARMED=01 POST=10 DONE=11
//   overflow_o      sticky: an entry was overwritten since the last arm
//
// state | meaning
// IDLE  | out of reset, nothing recorded
// ARMED | capturing pre-trigger writebacks, waiting for trig_i
// POST  | capturing the remaining post-trigger writebacks
// DONE  | capture stopped, buffer available for readout

module wb_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int STAT_W = 4,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm_i,
  input  logic              trig_i,
  input  logic [PTR_W:0]    post_cnt_i,
  input  logic              wb_i,
  input  logic [REG_AW-1:0] rd_num_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [STAT_W-1:0] status_i,
  input  logic              rd_i,
  output logic              rd_valid_o,
  output logic [CYC_W-1:0]  rd_cyc_o,
  output logic [REG_AW-1:0] rd_num_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [STAT_W-1:0] rd_stat_o,
  output logic [PTR_W:0]    count_o,
  output logic [1:0]        state_o,
  output logic              overflow_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  state_t state, state_nxt;

  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   post_cnt;
  logic [PTR_W:0]   post_load;
  logic [CYC_W-1:0] cyc;
  logic             overflow;
  logic             capture;
  logic             pop;
  logic             trig_take;

  logic [CYC_W-1:0]  mem_cyc  [DEPTH];
  logic [REG_AW-1:0] mem_num  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [STAT_W-1:0] mem_stat [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    pop       = 1'b0;
    trig_take = 1'b0;
    post_load = (post_cnt_i > DEPTH_C) ? DEPTH_C : post_cnt_i;
    if (arm_i) begin
      state_nxt = S_ARMED;
    end else begin
      case (state)
        S_ARMED: begin
          capture = wb_i;
          if (trig_i) begin
            trig_take = 1'b1;
            state_nxt = (post_load == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          capture = wb_i;
          // post_cnt is never 0 while in POST, so the last capture is at 1
          if (wb_i && post_cnt == (PTR_W+1)'(1)) state_nxt = S_DONE;
        end
        S_DONE: pop = rd_i && (count != '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      post_cnt <= '0;
      cyc      <= '0;
      overflow <= 1'b0;
    end else if (arm_i) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      post_cnt <= '0;
      cyc      <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == S_ARMED || state == S_POST) cyc <= cyc + CYC_W'(1);
      if (capture) begin
        wptr <= wptr + PTR_W'(1);
        if (count == DEPTH_C) begin
          // buffer full: drop the oldest entry to make room
          rptr     <= rptr + PTR_W'(1);
          overflow <= 1'b1;
        end else begin
          count <= count + (PTR_W+1)'(1);
        end
        if (state == S_POST) post_cnt <= post_cnt - (PTR_W+1)'(1);
      end
      if (trig_take) post_cnt <= post_load;
      if (pop) begin
        rptr  <= rptr + PTR_W'(1);
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem_cyc[wptr]  <= cyc;
      mem_num[wptr]  <= rd_num_i;
      mem_data[wptr] <= rd_data_i;
      mem_stat[wptr] <= status_i;
    end
  end

  assign rd_valid_o = (state == S_DONE) && (count != '0);
  assign rd_cyc_o   = rd_valid_o ? mem_cyc[rptr]  : '0;
  assign rd_num_o   = rd_valid_o ? mem_num[rptr]  : '0;
  assign rd_data_o  = rd_valid_o ? mem_data[rptr] : '0;
  assign rd_stat_o  = rd_valid_o ? mem_stat[rptr] : '0;
  assign count_o    = count;
  assign state_o    = state;
  assign overflow_o = overflow;

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
Synthesizable writeback trace recorder for the venus core. It captures every EX->RF writeback as a time-stamped entry: register number, data and execute status flags. Capture goes into a circular buffer with arm, trigger and post-trigger-count control. After capture stops, the buffer is drained in chronological order. It taps wb_exreg / rd_num_exreg / rd_data_exreg / status_r alongside core, giving on-chip visibility of the per-cycle writeback trace that simulation benches currently print with $display.

Parameters:
DATA_W, 16, width of rd_data.
REG_AW, 4, width of register number (16 GPRs).
STAT_W, 4, width of status flags.
DEPTH, 16, buffer entries; power of two, >= 2.
CYC_W, 16, cycle-stamp width.
PTR_W, $clog2(DEPTH), pointer width (derived).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
arm_i  in  1  pulse: clear buffer and start capture.
trig_i  in  1  trigger event.
post_cnt_i  in  PTR_W+1  number of writebacks to capture after the trigger; sampled on the trigger cycle.
wb_i  in  1  writeback valid.
rd_num_i  in  REG_AW  writeback register number.
rd_data_i  in  DATA_W  writeback data.
status_i  in  STAT_W  status flags in the writeback cycle.
rd_i  in  1  pop the oldest entry (honoured in DONE only).
rd_valid_o  out  1  an entry is presented.
rd_cyc_o  out  CYC_W  cycle stamp of the presented entry.
rd_num_o  out  REG_AW  register number of the presented entry.
rd_data_o  out  DATA_W  data of the presented entry.
rd_stat_o  out  STAT_W  status of the presented entry.
count_o  out  PTR_W+1  entries held, 0..DEPTH.
state_o  out  2  IDLE=00, ARMED=01, POST=10, DONE=11.
overflow_o  out  1  sticky: at least one entry was overwritten.

Behaviour:
- Reset (async, any time, including mid-capture or mid-drain):
  - state IDLE; write/read pointers 0; count_o 0; cycle counter 0; post counter 0; overflow_o 0.
  - rd_valid_o 0; all rd_*_o 0.
  - Memory contents are don't-care.
- arm_i in any state, edge: state->ARMED; pointers, count, cycle counter, overflow cleared. Any wb_i in that same cycle is NOT captured.
- Cycle counter: increments by 1 every clock in ARMED/POST, wraps modulo 2^CYC_W; frozen in IDLE/DONE. The entry stamp is the counter value during the capture cycle, so the first cycle after arming stamps 0.
- Capture, ARMED or POST with wb_i=1: write {cyc, rd_num_i, rd_data_i, status_i} at the write pointer; write pointer +1 (wraps mod DEPTH).
  - If count<DEPTH: count+1.
  - If count==DEPTH: oldest entry overwritten, read pointer +1, count stays at DEPTH, overflow_o set.
- ARMED + trig_i (arm_i low):
  - Any writeback in the trigger cycle is captured as a pre-trigger entry.
  - Load post counter = min(post_cnt_i, DEPTH).
  - Loaded value 0 -> DONE; otherwise -> POST.
- POST: each captured writeback decrements the post counter; the capture that reaches 0 moves the state to DONE at the same edge. trig_i ignored.
- arm_i and trig_i in the same cycle: arm wins. trig_i in IDLE/DONE: ignored.
- DONE:
  - No capture; wb_i ignored.
  - rd_valid_o = (count!=0). rd_*_o show the entry at the read pointer combinationally.
  - rd_i with rd_valid_o=1: read pointer +1, count-1 at the edge. rd_i with count 0: no effect.
  - In all other states rd_i is ignored.
- rd_*_o are 0 whenever rd_valid_o=0.
- Readout order is always oldest-first, correct across pointer wrap.

Test Plan:
- Reset: assert rst mid-POST with count=5 -> state_o=00, count_o=0, rd_valid_o=0, overflow_o=0 immediately (asynchronously), held through deassertion.
- Basic (DEPTH=16):
  - Stimulus: arm; writebacks in cycles 0,2,3 with (r1,0x0011), (r2,0x0022), (r3,0x0033); trig in cycle 4 with post_cnt_i=0.
  - Response: state DONE; count 3; pops return stamps 0,2,3 in that order with matching data; rd_valid_o drops after the 3rd pop.
- Post-trigger:
  - Stimulus: arm; trig in cycle 1 with post_cnt_i=2 and no writeback; writebacks in cycles 5,6,7.
  - Response: POST until the cycle-6 capture, then DONE; count 2; stamps 5,6; the cycle-7 writeback is absent.
- Overflow/wrap:
  - Stimulus: 20 consecutive writebacks with rd_data=0..19, trigger with post_cnt_i=0.
  - Response: count 16, overflow_o=1; readout 4..19 oldest-first; stamps 4..19.
- Precedence:
  - Stimulus: arm_i and trig_i together while ARMED with count=7.
  - Response: state ARMED, count 0, overflow 0.
  - Stimulus: trig_i in IDLE.
  - Response: state stays IDLE.
  - Stimulus: rd_i in ARMED.
  - Response: count unchanged.
- post_cnt saturation:
  - Stimulus: post_cnt_i=31 with DEPTH=16, then 16 writebacks.
  - Response: DONE after the 16th capture; the 17th writeback is not captured.
